// File: rtl/cc_pkg.sv
// Shared definitions for the condition-code checkpoint register:
// flag positions, default width/reset value and the per-cycle command decode.
package cc_pkg;

    localparam int CC_OF = 0;
    localparam int CC_SF = 1;
    localparam int CC_ZF = 2;

    localparam int CC_W = 3;

    localparam logic [CC_W-1:0] CC_RESET_VAL = 3'b100;

    typedef enum logic [2:0] {
        NONE,
        PUSH,
        POP,
        REPLACE,
        RESTORE
    } cc_cmd_e;

endpackage

// File: rtl/cc_ckpt_stack.sv
// LIFO of saved flag vectors with occupancy count and full/empty decode.
// Storage is not reset; only entries below count carry meaning.
module cc_ckpt_stack #(
    parameter int N     = 3,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_we,
    input  logic          repl_we,
    input  logic          dec,
    input  logic [N-1:0]  wr_data,
    output logic [N-1:0]  top,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] top_idx;

    assign wr_idx  = AW'(count);
    assign top_idx = AW'(count - CW'(1));

    assign top   = mem[top_idx];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push_we) begin
            count <= count + CW'(1);
        end else if (dec) begin
            count <= count - CW'(1);
        end
    end

    // Data path carries no reset; a write during reset lands above count and is harmless.
    always_ff @(posedge clk) begin
        if (push_we) begin
            mem[wr_idx] <= wr_data;
        end else if (repl_we) begin
            mem[top_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/cc_ckpt_reg.sv
// Condition-code register with per-flag masked writes and a checkpoint
// stack: push saves flags on a predicted branch, restore recovers them on a mispredict.
module cc_ckpt_reg
    import cc_pkg::*;
#(
    parameter int             N         = CC_W,
    parameter int             DEPTH     = 4,
    parameter logic [N-1:0]   RESET_VAL = N'(CC_RESET_VAL)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N-1:0]                 in,
    input  logic                         set,
    input  logic [N-1:0]                 mask,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         restore,
    output logic [N-1:0]                 out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int CW = $clog2(DEPTH + 1);

    cc_cmd_e      cmd;
    logic         err_evt;
    logic [N-1:0] top;
    logic [N-1:0] flag_nxt;
    logic         push_we;
    logic         repl_we;
    logic         dec;

    function automatic logic [N-1:0] merge_flags(input logic [N-1:0] cur,
                                                 input logic [N-1:0] upd,
                                                 input logic [N-1:0] msk);
        return (cur & ~msk) | (upd & msk);
    endfunction

    // A restore request always blocks push/pop, even when it is itself
    // ineffective on an empty stack; push+pop on empty degrades to a plain push.
    always_comb begin
        cmd     = NONE;
        err_evt = 1'b0;
        if (restore) begin
            if (!empty) cmd = RESTORE;
            err_evt = empty;
        end else if (push && pop && !empty) begin
            cmd = REPLACE;
        end else if (push) begin
            if (!full) cmd = PUSH;
            else       err_evt = 1'b1;
        end else if (pop) begin
            if (!empty) cmd = POP;
            else        err_evt = 1'b1;
        end
    end

    always_comb begin
        flag_nxt = out;
        if (cmd == RESTORE) begin
            flag_nxt = top;
        end else if (set) begin
            flag_nxt = merge_flags(out, in, mask);
        end
    end

    assign push_we = (cmd == PUSH) && !reset;
    assign repl_we = (cmd == REPLACE) && !reset;
    assign dec     = (cmd == POP) || (cmd == RESTORE);

    cc_ckpt_stack #(
        .N     (N),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_we (push_we),
        .repl_we (repl_we),
        .dec     (dec),
        .wr_data (out),
        .top     (top),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= RESET_VAL;
            err <= 1'b0;
        end else begin
            out <= flag_nxt;
            if (err_evt) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cc_ckpt_reg.sv
// Directed plus randomized bench for cc_ckpt_reg against a queue-based reference model.
module tb_cc_ckpt_reg;

    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, set, push, pop, restore;
    logic [N-1:0]  in, mask, out;
    logic [CW-1:0] count;
    logic          full, empty, err;

    always #5 clk = ~clk;

    cc_ckpt_reg #(.N(N), .DEPTH(DEPTH), .RESET_VAL(3'b100)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .set     (set),
        .mask    (mask),
        .push    (push),
        .pop     (pop),
        .restore (restore),
        .out     (out),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .err     (err)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] m_out = 3'b100;
    logic [N-1:0] m_stk [$];
    bit           m_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: flags as a plain vector, checkpoints as a queue whose back is the top.
    task automatic model_step();
        logic [N-1:0] nf;
        if (reset) begin
            m_out = 3'b100;
            m_stk.delete();
            m_err = 1'b0;
        end else if (restore) begin
            if (m_stk.size() > 0) begin
                m_out = m_stk.pop_back();
            end else begin
                m_err = 1'b1;
                if (set) m_out = (m_out & ~mask) | (in & mask);
            end
        end else begin
            nf = set ? ((m_out & ~mask) | (in & mask)) : m_out;
            if (push && pop && m_stk.size() > 0) begin
                m_stk[m_stk.size()-1] = m_out;
            end else if (push) begin
                if (m_stk.size() < DEPTH) m_stk.push_back(m_out);
                else m_err = 1'b1;
            end else if (pop) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else m_err = 1'b1;
            end
            m_out = nf;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".out"},   32'(out),   32'(m_out));
        chk({tag, ".count"}, 32'(count), 32'(m_stk.size()));
        chk({tag, ".full"},  32'(full),  32'(m_stk.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(m_stk.size() == 0));
        chk({tag, ".err"},   32'(err),   32'(m_err));
    endtask

    task automatic drive(input string tag, input logic r, input logic s,
                         input logic [N-1:0] m, input logic [N-1:0] i,
                         input logic p, input logic po, input logic rs);
        reset = r; set = s; mask = m; in = i; push = p; pop = po; restore = rs;
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        reset = 1'b1; set = 1'b0; mask = '0; in = '0; push = 1'b0; pop = 1'b0; restore = 1'b0;
        #1;
        drive("rst0", 1, 0, 0, 0, 0, 0, 0);
        drive("rst1", 1, 1, 7, 7, 1, 0, 0);
        chk("reset.out", 32'(out), 32'h4);

        drive("set_all", 0, 1, 3'b111, 3'b011, 0, 0, 0);
        chk("plan.set_all", 32'(out), 32'h3);
        drive("set_mask", 0, 1, 3'b001, 3'b100, 0, 0, 0);
        chk("plan.set_mask", 32'(out), 32'h2);

        drive("prep",  0, 1, 7, 3'b001, 0, 0, 0);
        drive("push1", 0, 1, 7, 3'b010, 1, 0, 0);
        drive("push2", 0, 1, 7, 3'b011, 1, 0, 0);
        drive("push3", 0, 1, 7, 3'b101, 1, 0, 0);
        drive("push4", 0, 0, 0, 0, 1, 0, 0);
        chk("plan.full",  32'(full),  32'h1);
        chk("plan.count", 32'(count), 32'h4);
        drive("push5", 0, 0, 0, 0, 1, 0, 0);
        chk("plan.ovf_count", 32'(count), 32'h4);
        chk("plan.ovf_err",   32'(err),   32'h1);
        drive("rest1", 0, 0, 0, 0, 0, 0, 1);
        chk("plan.rest1", 32'(out), 32'h5);
        drive("rest2", 0, 0, 0, 0, 0, 0, 1);
        chk("plan.rest2", 32'(out), 32'h3);
        drive("rest3", 0, 0, 0, 0, 0, 0, 1);
        chk("plan.rest3", 32'(out), 32'h2);
        drive("rest4", 0, 0, 0, 0, 0, 0, 1);
        chk("plan.rest4", 32'(out), 32'h1);
        chk("plan.empty", 32'(empty), 32'h1);

        drive("rst2",    1, 0, 0, 0, 0, 0, 0);
        drive("set110",  0, 1, 7, 3'b110, 0, 0, 0);
        drive("setpush", 0, 1, 7, 3'b001, 1, 0, 0);
        chk("plan.setpush", 32'(out), 32'h1);
        drive("rest110", 0, 0, 0, 0, 0, 0, 1);
        chk("plan.rest110", 32'(out), 32'h6);

        drive("pushA",   0, 0, 0, 0, 1, 0, 0);
        drive("pushB",   0, 1, 7, 3'b011, 1, 0, 0);
        drive("restset", 0, 1, 7, 3'b001, 0, 0, 1);
        chk("plan.restset", 32'(out), 32'h6);
        drive("set2",    0, 1, 7, 3'b010, 0, 0, 0);
        drive("pushpop", 0, 0, 0, 0, 1, 1, 0);
        chk("plan.pushpop_count", 32'(count), 32'h1);
        drive("set3",    0, 1, 7, 3'b111, 0, 0, 0);
        drive("restpp",  0, 0, 0, 0, 0, 0, 1);
        chk("plan.pushpop_top", 32'(out), 32'h2);

        drive("rst3",     1, 0, 0, 0, 0, 0, 0);
        drive("rest_emp", 0, 1, 7, 3'b111, 0, 0, 1);
        chk("plan.rest_emp_out", 32'(out),   32'h7);
        chk("plan.rest_emp_err", 32'(err),   32'h1);
        drive("pp_emp",   1, 0, 0, 0, 0, 0, 0);
        drive("pp_emp2",  0, 0, 0, 0, 1, 1, 0);
        chk("plan.pp_empty_err", 32'(err), 32'h0);

        drive("p1", 0, 0, 0, 0, 1, 0, 0);
        drive("p2", 0, 0, 0, 0, 1, 0, 0);
        chk("plan.count3", 32'(count), 32'h3);
        drive("rst_spec", 1, 1, 7, 3'b011, 1, 0, 0);
        chk("plan.rst_out",   32'(out),   32'h4);
        chk("plan.rst_count", 32'(count), 32'h0);
        chk("plan.rst_empty", 32'(empty), 32'h1);
        chk("plan.rst_err",   32'(err),   32'h0);

        for (int k = 0; k < 600; k++) begin
            drive("rand",
                  ($urandom_range(0, 63) == 0),
                  1'($urandom),
                  3'($urandom),
                  3'($urandom),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
